// File: rtl/gearbox_narrow_to_wide.sv
// Narrow-to-wide stream gearbox: packs IN_W-bit beats into RATIO-lane words.
// Completed words go into a show-ahead FIFO with a keep mask and a last flag.
module gearbox_narrow_to_wide #(
  parameter int IN_W      = 64,
  parameter int RATIO     = 8,
  parameter int DEPTH     = 256,
  parameter int AFULL_GAP = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [RATIO*IN_W-1:0]     out_data,
  output logic [RATIO-1:0]          out_keep,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      out_afull
);

  localparam int OUT_W = RATIO * IN_W;
  localparam int IDX_W = $clog2(RATIO);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int ENT_W = OUT_W + RATIO + 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [OUT_W-1:0] word_s;
  logic [RATIO-1:0] word_keep_s;
  logic [ENT_W-1:0] head_s;
  logic             full_s, empty_s, push_s, pop_s, commit_s;

  // Readiness uses the pre-pop level, so a same-cycle pop never frees a slot.
  assign full_s   = (level_q == LW'(DEPTH));
  assign empty_s  = (level_q == {LW{1'b0}});
  assign in_ready = rst && !full_s;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = out_valid && out_ready;

  // Current word with the incoming beat merged into its lane.
  always_comb begin
    word_s                       = asm_q;
    word_keep_s                  = keep_q;
    word_s[idx_q*IN_W +: IN_W]   = in_data;
    word_keep_s[idx_q]           = 1'b1;
    commit_s = push_s && ((idx_q == IDX_W'(RATIO - 1)) || in_last);
  end

  // Next-state for the packer, the FIFO pointers and the shared level count.
  always_comb begin
    idx_d    = idx_q;
    asm_d    = asm_q;
    keep_d   = keep_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (commit_s) begin
      idx_d    = {IDX_W{1'b0}};
      asm_d    = {OUT_W{1'b0}};
      keep_d   = {RATIO{1'b0}};
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else if (push_s) begin
      idx_d  = idx_q + IDX_W'(1);
      asm_d  = word_s;
      keep_d = word_keep_s;
    end else begin
      idx_d  = idx_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({commit_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State register; reset dominates the flush, both drop any partial word.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      idx_q    <= {IDX_W{1'b0}};
      asm_q    <= {OUT_W{1'b0}};
      keep_q   <= {RATIO{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      keep_q   <= keep_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[wr_ptr_q] <= {in_last, word_keep_s, word_s};
    end
  end

  assign head_s    = mem_q[rd_ptr_q];
  assign out_valid = !empty_s;
  assign out_data  = out_valid ? head_s[OUT_W-1:0] : {OUT_W{1'b0}};
  assign out_keep  = out_valid ? head_s[OUT_W +: RATIO] : {RATIO{1'b0}};
  assign out_last  = out_valid && head_s[ENT_W-1];
  assign level     = level_q;
  assign out_afull = (level_q >= LW'(DEPTH - AFULL_GAP));

  gearbox_narrow_to_wide_chk #(.LW(LW), .DEPTH(DEPTH)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .level    (level_q)
  );

endmodule

// Simulation-only properties for the gearbox FIFO.
module gearbox_narrow_to_wide_chk #(
  parameter int LW    = 9,
  parameter int DEPTH = 256
) (
  input logic          clk,
  input logic          rst,
  input logic          clr,
  input logic          in_valid,
  input logic          in_ready,
  input logic [LW-1:0] level
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst || clr)
    !(in_valid && in_ready && (level == LW'(DEPTH))));

  a_level_in_range: assert property (@(posedge clk) disable iff (!rst || clr)
    level <= LW'(DEPTH));

endmodule

// File: tb/tb_gearbox_narrow_to_wide.sv
// Bench for gearbox_narrow_to_wide: directed checks on the 64x8/256 build and a
// random run on a 32x4/16 build, both compared every cycle against queue models.
module tb_gearbox_narrow_to_wide;

  localparam int BW = 64, BR = 8, BD = 256;
  localparam int SW = 32, SR = 4, SD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [63:0]  b_in_data;
  logic         b_clr, b_in_valid, b_in_last, b_in_ready;
  logic [511:0] b_out_data;
  logic [7:0]   b_out_keep;
  logic         b_out_last, b_out_valid, b_out_ready, b_out_afull;
  logic [8:0]   b_level;

  logic [31:0]  s_in_data;
  logic         s_clr, s_in_valid, s_in_last, s_in_ready;
  logic [127:0] s_out_data;
  logic [3:0]   s_out_keep;
  logic         s_out_last, s_out_valid, s_out_ready, s_out_afull;
  logic [4:0]   s_level;

  gearbox_narrow_to_wide #(.IN_W(BW), .RATIO(BR), .DEPTH(BD), .AFULL_GAP(4)) u_big (
    .clk(clk), .rst(rst), .clr(b_clr),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .level(b_level), .out_afull(b_out_afull)
  );

  gearbox_narrow_to_wide #(.IN_W(SW), .RATIO(SR), .DEPTH(SD), .AFULL_GAP(4)) u_small (
    .clk(clk), .rst(rst), .clr(s_clr),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_last(s_in_last), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_keep(s_out_keep), .out_last(s_out_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .level(s_level), .out_afull(s_out_afull)
  );

  typedef struct {
    logic [511:0] d;
    logic [7:0]   k;
    logic         l;
  } word_t;

  word_t        bq[$];
  word_t        sq[$];
  word_t        tmp_w;
  int           bcnt = 0, scnt = 0, b_pre, s_pre;
  logic [511:0] basm = '0;
  logic [7:0]   bkeep = '0;
  logic [127:0] sasm = '0;
  logic [3:0]   skeep = '0;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference packers: a word is the list of beats since the last close.
  initial forever begin
    @(posedge clk);
    if (!rst || b_clr) begin
      bq.delete(); bcnt = 0; basm = '0; bkeep = '0;
    end else begin
      b_pre = bq.size();
      if (b_pre > 0 && b_out_ready) tmp_w = bq.pop_front();
      if (b_in_valid && b_pre < BD) begin
        basm[bcnt*BW +: BW] = b_in_data;
        bkeep[bcnt] = 1'b1;
        if (bcnt == BR - 1 || b_in_last) begin
          bq.push_back('{basm, bkeep, b_in_last});
          bcnt = 0; basm = '0; bkeep = '0;
        end else bcnt++;
      end
    end
    if (!rst || s_clr) begin
      sq.delete(); scnt = 0; sasm = '0; skeep = '0;
    end else begin
      s_pre = sq.size();
      if (s_pre > 0 && s_out_ready) tmp_w = sq.pop_front();
      if (s_in_valid && s_pre < SD) begin
        sasm[scnt*SW +: SW] = s_in_data;
        skeep[scnt] = 1'b1;
        if (scnt == SR - 1 || s_in_last) begin
          sq.push_back('{{384'b0, sasm}, {4'b0, skeep}, s_in_last});
          scnt = 0; sasm = '0; skeep = '0;
        end else scnt++;
      end
    end
  end

  // Per-cycle comparison of both builds against the models.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp("b_in_ready", b_in_ready, rst && (bq.size() < BD));
      cmp("b_out_valid", b_out_valid, bq.size() > 0);
      cmp("b_level", b_level, bq.size());
      cmp("b_out_afull", b_out_afull, bq.size() >= BD - 4);
      if (bq.size() > 0) begin
        cmp("b_out_data", b_out_data, bq[0].d);
        cmp("b_out_keep", b_out_keep, bq[0].k);
        cmp("b_out_last", b_out_last, bq[0].l);
      end
      cmp("s_in_ready", s_in_ready, rst && (sq.size() < SD));
      cmp("s_out_valid", s_out_valid, sq.size() > 0);
      cmp("s_level", s_level, sq.size());
      cmp("s_out_afull", s_out_afull, sq.size() >= SD - 4);
      if (sq.size() > 0) begin
        cmp("s_out_data", s_out_data, sq[0].d);
        cmp("s_out_keep", s_out_keep, sq[0].k);
        cmp("s_out_last", s_out_last, sq[0].l);
      end
    end
  end

  task automatic big_send(input logic [63:0] d, input logic l);
    bit got;
    got = 1'b0;
    b_in_data = d; b_in_last = l; b_in_valid = 1'b1;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      got = b_in_ready;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    if (!got) cmp("send_timeout", got, 1);
  endtask

  task automatic big_pop();
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  logic [511:0] e;
  int nv, s_acc, cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    b_clr = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
    s_clr = 1'b0; s_in_data = '0; s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    cmp("rst_level", b_level, 0);
    cmp("rst_out_valid", b_out_valid, 0);
    cmp("rst_in_ready", b_in_ready, 0);
    cmp("rst_out_keep", b_out_keep, 0);
    cmp("rst_out_last", b_out_last, 0);
    cmp("rst_out_afull", b_out_afull, 0);
    rst = 1'b1;
    #1;
    cmp("ready_after_rst", b_in_ready, 1);

    // 1: eight plain beats make one full word.
    for (int k = 0; k < 8; k++) big_send(64'(k), 1'b0);
    e = '0;
    for (int k = 0; k < 8; k++) e[k*64 +: 64] = 64'(k);
    cmp("t1_level", b_level, 1);
    cmp("t1_keep", b_out_keep, 8'hFF);
    cmp("t1_last", b_out_last, 0);
    cmp("t1_data", b_out_data, e);
    big_pop();
    cmp("t1_level_after_pop", b_level, 0);

    // 2: in_last closes a three-beat word early.
    big_send(64'hAAAA_0000_0000_0001, 1'b0);
    big_send(64'hBBBB_0000_0000_0002, 1'b0);
    big_send(64'hCCCC_0000_0000_0003, 1'b1);
    e = '0;
    e[63:0] = 64'hAAAA_0000_0000_0001;
    e[127:64] = 64'hBBBB_0000_0000_0002;
    e[191:128] = 64'hCCCC_0000_0000_0003;
    cmp("t2_keep", b_out_keep, 8'h07);
    cmp("t2_last", b_out_last, 1);
    cmp("t2_data", b_out_data, e);
    big_pop();
    big_send(64'hDDDD_0000_0000_0004, 1'b1);
    e = '0;
    e[63:0] = 64'hDDDD_0000_0000_0004;
    cmp("t2_next_keep", b_out_keep, 8'h01);
    cmp("t2_next_data", b_out_data, e);
    big_pop();

    // 3: fill the FIFO, hold off extra beats, free one slot, drain.
    for (int i = 0; i < 2048; i++) begin
      big_send({32'hF00D, 32'(i)}, 1'b0);
      if (i % 8 == 7) begin
        if ((i + 1) / 8 == 251) cmp("t3_afull_251", b_out_afull, 0);
        if ((i + 1) / 8 == 252) cmp("t3_afull_252", b_out_afull, 1);
      end
    end
    cmp("t3_full_level", b_level, 256);
    cmp("t3_full_ready", b_in_ready, 0);
    cmp("t3_full_afull", b_out_afull, 1);
    cmp("t3_head_lane0", b_out_data[63:0], {32'hF00D, 32'd0});
    b_in_data = 64'hDEAD; b_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("t3_held_level", b_level, 256);
    big_pop();
    cmp("t3_pop_level", b_level, 255);
    cmp("t3_pop_ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int n = 0; n < 400 && b_level != 0; n++) begin
      @(posedge clk); #1;
    end
    b_out_ready = 1'b0;
    cmp("t3_drained", b_level, 0);
    b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;

    // 4: continuous traffic both sides.
    nv = 0;
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_last = 1'b0;
    for (int c = 0; c < 64; c++) begin
      b_in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      cmp("t4_level_le1", b_level <= 1, 1);
      if (b_out_valid) nv++;
    end
    b_in_valid = 1'b0;
    cmp("t4_words", nv, 8);
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    cmp("t4_level_end", b_level, 0);

    // 5: flush mid-word with two words queued.
    for (int i = 0; i < 21; i++) big_send(64'(500 + i), 1'b0);
    cmp("t5_level_before", b_level, 2);
    b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;
    cmp("t5_clr_level", b_level, 0);
    cmp("t5_clr_valid", b_out_valid, 0);
    cmp("t5_clr_keep", b_out_keep, 0);
    cmp("t5_clr_last", b_out_last, 0);
    for (int k = 0; k < 8; k++) big_send(64'(100 + k), 1'b0);
    e = '0;
    for (int k = 0; k < 8; k++) e[k*64 +: 64] = 64'(100 + k);
    cmp("t5_fresh_level", b_level, 1);
    cmp("t5_fresh_keep", b_out_keep, 8'hFF);
    cmp("t5_fresh_data", b_out_data, e);
    big_pop();

    // 6: random beats, random in_last and phased backpressure on the small build.
    s_acc = 0; cyc = 0;
    while (s_acc < 10000 && cyc < 60000) begin
      s_in_valid = ($urandom_range(0, 3) != 0);
      s_in_last = ($urandom_range(0, 7) == 0);
      s_in_data = $urandom;
      s_out_ready = ((cyc / 500) % 2 == 1) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 1);
      @(negedge clk);
      if (s_in_valid && s_in_ready) s_acc++;
      @(posedge clk); #1;
      cyc++;
    end
    cmp("t6_beats", s_acc, 10000);
    s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    cmp("t6_drained", s_level, 0);
    s_out_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
